// File: rtl/ex_alu_seq.sv
// Execute-stage ALU with a registered result, zero/less-than flags and an optional
// bit-serial shifter that stalls the front end through a ready/valid handshake.
module ex_alu_seq #(
  parameter int DATA_W       = 32,
  parameter bit SERIAL_SHIFT = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [3:0]        ALUOp,
  input  logic [DATA_W-1:0] inA,
  input  logic [DATA_W-1:0] inB,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              lt
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SUBU  = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_SLT   = 4'd9;
  localparam logic [3:0] OP_SLTU  = 4'd10;
  localparam logic [3:0] OP_LUI   = 4'd11;
  localparam logic [3:0] OP_AUIPC = 4'd12;

  typedef enum logic { IDLE, SHIFT } state_t;
  typedef enum logic [1:0] { SH_LL, SH_RL, SH_RA } shift_t;

  state_t              state;
  state_t              state_next;
  shift_t              sh_kind;
  logic [DATA_W-1:0]   work;
  logic [DATA_W-1:0]   work_shifted;
  logic [4:0]          cnt;
  logic [4:0]          shamt;
  logic                is_shift;
  logic                accept;
  logic                start_serial;
  logic                lt_s;
  logic                lt_u;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_lt;

  assign shamt        = inB[4:0];
  assign is_shift     = (ALUOp == OP_SLL) || (ALUOp == OP_SRL) || (ALUOp == OP_SRA);
  assign in_ready     = (state == IDLE);
  assign accept       = in_valid && in_ready && !flush;
  // A zero-distance shift finishes through the single-cycle path.
  assign start_serial = accept && SERIAL_SHIFT && is_shift && (shamt != 5'd0);
  assign lt_s         = $signed(inA) < $signed(inB);
  assign lt_u         = inA < inB;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default is how latches get inferred.
  always_comb begin
    alu_res = inA + inB;
    alu_lt  = 1'b0;
    case (ALUOp)
      OP_ADD, OP_AUIPC: alu_res = inA + inB;
      OP_SUB:  begin alu_res = inA - inB; alu_lt = lt_s; end
      OP_SUBU: begin alu_res = inA - inB; alu_lt = lt_u; end
      OP_XOR:  alu_res = inA ^ inB;
      OP_OR:   alu_res = inA | inB;
      OP_AND:  alu_res = inA & inB;
      OP_SLL:  alu_res = SERIAL_SHIFT ? inA : (inA << shamt);
      OP_SRL:  alu_res = SERIAL_SHIFT ? inA : (inA >> shamt);
      OP_SRA:  alu_res = SERIAL_SHIFT ? inA : DATA_W'($signed(inA) >>> shamt);
      OP_SLT:  begin alu_res = {{(DATA_W-1){1'b0}}, lt_s}; alu_lt = lt_s; end
      OP_SLTU: begin alu_res = {{(DATA_W-1){1'b0}}, lt_u}; alu_lt = lt_u; end
      OP_LUI:  alu_res = inB;
      default: alu_res = inA + inB;
    endcase
  end

  always_comb begin
    work_shifted = work;
    case (sh_kind)
      SH_LL:   work_shifted = {work[DATA_W-2:0], 1'b0};
      SH_RL:   work_shifted = {1'b0, work[DATA_W-1:1]};
      SH_RA:   work_shifted = {work[DATA_W-1], work[DATA_W-1:1]};
      default: work_shifted = work;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_serial) state_next = SHIFT;
      SHIFT:   if (flush || cnt == 5'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      lt        <= 1'b0;
      work      <= '0;
      cnt       <= 5'd0;
      sh_kind   <= SH_LL;
    end else begin
      out_valid <= 1'b0;
      if (state == SHIFT) begin
        work <= work_shifted;
        cnt  <= cnt - 5'd1;
        if (flush) begin
          cnt <= 5'd0;
        end else if (cnt == 5'd1) begin
          result    <= work_shifted;
          zero      <= (work_shifted == '0);
          lt        <= 1'b0;
          out_valid <= 1'b1;
        end
      end else if (start_serial) begin
        work <= inA;
        cnt  <= shamt;
        case (ALUOp)
          OP_SLL:  sh_kind <= SH_LL;
          OP_SRL:  sh_kind <= SH_RL;
          default: sh_kind <= SH_RA;
        endcase
      end else if (accept) begin
        result    <= alu_res;
        zero      <= (alu_res == '0);
        lt        <= alu_lt;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_seq.sv
// Self-checking bench: a serial-shift and a barrel-shift instance share stimulus and
// are compared every cycle against a transaction-level model plus literal expectations.
module tb_ex_alu_seq;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_SUBU = 4'd2,  OP_XOR = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4,  OP_AND = 4'd5,  OP_SLL  = 4'd6,  OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8,  OP_SLT = 4'd9,  OP_SLTU = 4'd10, OP_LUI = 4'd11;
  localparam logic [3:0] OP_AUIPC = 4'd12;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  alu_op = 4'd0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;

  logic        ser_ready, ser_ov, ser_zero, ser_lt;
  logic [31:0] ser_res;
  logic        bar_ready, bar_ov, bar_zero, bar_lt;
  logic [31:0] bar_res;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  ex_alu_seq #(.DATA_W(32), .SERIAL_SHIFT(1'b1)) dut_ser (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ser_ready),
    .flush(flush), .ALUOp(alu_op), .inA(in_a), .inB(in_b),
    .out_valid(ser_ov), .result(ser_res), .zero(ser_zero), .lt(ser_lt)
  );

  ex_alu_seq #(.DATA_W(32), .SERIAL_SHIFT(1'b0)) dut_bar (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(bar_ready),
    .flush(flush), .ALUOp(alu_op), .inA(in_a), .inB(in_b),
    .out_valid(bar_ov), .result(bar_res), .zero(bar_zero), .lt(bar_lt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] f_res(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      OP_SUB, OP_SUBU: return a - b;
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return 32'($signed(a) >>> b[4:0]);
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_LUI:  return b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic f_lt(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b);
    if (op == OP_SUB || op == OP_SLT)   return $signed(a) < $signed(b);
    if (op == OP_SUBU || op == OP_SLTU) return a < b;
    return 1'b0;
  endfunction

  // Index 0 models the serial instance, index 1 the barrel instance.
  int          m_busy [2] = '{0, 0};
  logic [31:0] m_pend [2] = '{0, 0};
  logic [31:0] m_res  [2] = '{0, 0};
  logic        m_ov   [2] = '{0, 0};
  logic        m_zero [2] = '{0, 0};
  logic        m_lt   [2] = '{0, 0};

  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_busy[i] = 0; m_pend[i] = '0; m_res[i] = '0;
        m_ov[i] = 1'b0; m_zero[i] = 1'b0; m_lt[i] = 1'b0;
      end else begin
        m_ov[i] = 1'b0;
        if (m_busy[i] > 0) begin
          if (flush) m_busy[i] = 0;
          else begin
            m_busy[i]--;
            if (m_busy[i] == 0) begin
              m_ov[i] = 1'b1; m_res[i] = m_pend[i];
              m_zero[i] = (m_pend[i] == 0); m_lt[i] = 1'b0;
            end
          end
        end else if (in_valid && !flush) begin
          if (i == 0 && (alu_op == OP_SLL || alu_op == OP_SRL || alu_op == OP_SRA)
              && in_b[4:0] != 5'd0) begin
            m_busy[i] = int'(in_b[4:0]);
            m_pend[i] = f_res(alu_op, in_a, in_b);
          end else begin
            m_ov[i]   = 1'b1;
            m_res[i]  = f_res(alu_op, in_a, in_b);
            m_zero[i] = (m_res[i] == 0);
            m_lt[i]   = f_lt(alu_op, in_a, in_b);
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    check("ser in_ready", 32'(ser_ready), 32'(m_busy[0] == 0));
    check("ser out_valid", 32'(ser_ov), 32'(m_ov[0]));
    check("ser result", ser_res, m_res[0]);
    check("ser zero", 32'(ser_zero), 32'(m_zero[0]));
    check("ser lt", 32'(ser_lt), 32'(m_lt[0]));
    check("bar in_ready", 32'(bar_ready), 32'(m_busy[1] == 0));
    check("bar out_valid", 32'(bar_ov), 32'(m_ov[1]));
    check("bar result", bar_res, m_res[1]);
    check("bar zero", 32'(bar_zero), 32'(m_zero[1]));
    check("bar lt", 32'(bar_lt), 32'(m_lt[1]));
  end

  // ---------------- directed stimulus ----------------
  task automatic present(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; alu_op = op; in_a = a; in_b = b;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; alu_op = 4'd0; in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678;
  endtask

  // Entered at the negedge of T+1; leaves at the first negedge with in_ready high.
  task automatic wait_done(output int stall);
    stall = 0;
    while (ser_ready === 1'b0 && stall < 100) begin
      stall++;
      @(negedge clock);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        lt;
  } vec_t;

  vec_t vecs [10] = '{
    '{OP_SUBU,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1},
    '{OP_SUB,   32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0},
    '{OP_SLT,   32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1'b1},
    '{OP_XOR,   32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0},
    '{OP_OR,    32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0},
    '{OP_AND,   32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0},
    '{OP_LUI,   32'h0000_0077, 32'h1234_5000, 32'h1234_5000, 1'b0},
    '{OP_AUIPC, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 1'b0},
    '{4'd15,    32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0},
    '{OP_SLTU,  32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b0}
  };

  initial begin
    int stall;
    idle_in();
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    check("reset out_valid", 32'(ser_ov), 32'd0);
    check("reset result", ser_res, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("in_ready after reset", 32'(ser_ready), 32'd1);

    // ADD then back-to-back SUB
    present(OP_ADD, 32'd5, 32'd7);
    @(negedge clock);
    check("add out_valid", 32'(ser_ov), 32'd1);
    check("add result", ser_res, 32'd12);
    check("add zero", 32'(ser_zero), 32'd0);
    present(OP_SUB, 32'd9, 32'd9);
    @(negedge clock);
    check("sub result", ser_res, 32'd0);
    check("sub zero", 32'(ser_zero), 32'd1);
    idle_in();
    @(negedge clock);
    check("pulse ends", 32'(ser_ov), 32'd0);

    // SRA serial vs barrel
    present(OP_SRA, 32'h8000_0000, 32'd4);
    @(negedge clock);
    idle_in();
    check("bar sra valid", 32'(bar_ov), 32'd1);
    check("bar sra result", bar_res, 32'hF800_0000);
    wait_done(stall);
    check("sra stall cycles", 32'(stall), 32'd4);
    check("sra out_valid", 32'(ser_ov), 32'd1);
    check("sra result", ser_res, 32'hF800_0000);

    // zero-distance shift, then 31-bit shift
    present(OP_SLL, 32'h0000_1234, 32'd0);
    @(negedge clock);
    check("sll0 ready", 32'(ser_ready), 32'd1);
    check("sll0 valid", 32'(ser_ov), 32'd1);
    check("sll0 result", ser_res, 32'h0000_1234);
    present(OP_SLL, 32'd1, 32'd31);
    @(negedge clock);
    idle_in();
    wait_done(stall);
    check("sll31 stall cycles", 32'(stall), 32'd31);
    check("sll31 result", ser_res, 32'h8000_0000);

    // compare / logic table, back-to-back
    for (int i = 0; i < 10; i++) begin
      present(vecs[i].op, vecs[i].a, vecs[i].b);
      @(negedge clock);
      check($sformatf("vec%0d result", i), ser_res, vecs[i].res);
      check($sformatf("vec%0d lt", i), 32'(ser_lt), 32'(vecs[i].lt));
    end
    idle_in();
    @(negedge clock);

    // flush kills an in-flight shift
    present(OP_SRL, 32'hFFFF_FFFF, 32'd20);
    @(negedge clock);
    idle_in();
    @(negedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush ready", 32'(ser_ready), 32'd1);
    check("flush no valid", 32'(ser_ov), 32'd0);
    present(OP_ADD, 32'd3, 32'd4);
    @(negedge clock);
    idle_in();
    check("post-flush valid", 32'(ser_ov), 32'd1);
    check("post-flush result", ser_res, 32'd7);
    repeat (25) @(negedge clock);

    // async reset in the middle of a shift
    present(OP_SUB, 32'd1, 32'd2);
    @(negedge clock);
    present(OP_SRA, 32'h8000_0000, 32'd10);
    @(negedge clock);
    idle_in();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst out_valid", 32'(ser_ov), 32'd0);
    check("arst result", ser_res, 32'd0);
    check("arst zero", 32'(ser_zero), 32'd0);
    check("arst lt", 32'(ser_lt), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("arst ready", 32'(ser_ready), 32'd1);
    repeat (3) @(negedge clock);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
